pwm_voice_mixer: RTL and testbench

Parametrised mixer and output stage for the synth datapath. It sums NUM_CH channel samples, masked per channel, into one duty value. A single-entry pending buffer behind a valid/ready handshake holds the next value. The active duty is drawn as a W-bit PWM waveform on the GPIO sigout pin. Chip-select gating lives inside the block: cs low soft-clears the stage.

---
 rtl/pwm_voice_mixer.sv | 148 ++++++++++++++
 tb/tb_pwm_voice_mixer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_voice_mixer.sv
// pwm_voice_mixer
// Mixes NUM_CH unsigned channel samples (masked per channel) into one duty
// value, buffers one pending mix behind a valid/ready handshake, and plays the
// active duty as a W-bit PWM waveform on sigout. cs low soft-clears the stage.
// Pending mixes are promoted to the active duty only at PWM period boundaries,
// so a period is never drawn with two different duty values.

module pwm_voice_mixer #(
   parameter int NUM_CH = 4,   // power of two, at least 2
   parameter int W      = 8,   // sample / duty / PWM counter width
   parameter int SAT    = 0    // 0 = average, 1 = saturating sum
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic [NUM_CH-1:0]     ch_en,
   input  logic [NUM_CH*W-1:0]   samples,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  sigout,
   output logic                  period_end,
   output logic [W-1:0]          mix_level
);

   localparam int LG = $clog2(NUM_CH);
   localparam int SW = W + LG;
   localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
   localparam logic [W-1:0] DUTY_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

   // Sum of enabled samples, then either divide by the channel count (the
   // divisor is fixed, not the number of enabled channels) or clamp to full
   // scale. The accumulator is wide enough that the sum never overflows.
   function automatic logic [W-1:0] mix_f(
      input logic [NUM_CH-1:0]   en,
      input logic [NUM_CH*W-1:0] smp
   );
      logic [SW-1:0] acc_v;
      logic [W-1:0]  res_v;
      acc_v = {SW{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         if (en[k]) begin
            acc_v = acc_v + {{LG{1'b0}}, smp[k*W +: W]};
         end else begin
            acc_v = acc_v;
         end
      end
      if (SAT != 0) begin
         if (acc_v > {{LG{1'b0}}, DUTY_MAX}) begin
            res_v = DUTY_MAX;
         end else begin
            res_v = acc_v[W-1:0];
         end
      end else begin
         res_v = acc_v[SW-1:LG];
      end
      return res_v;
   endfunction

   // State
   logic [W-1:0] cnt_r;
   logic [W-1:0] duty_r;
   logic [W-1:0] pend_r;
   logic         pend_full_r;
   logic         sigout_r;

   // Decoded control
   logic [W-1:0] mix_s;
   logic         cnt_max_s;
   logic         period_end_s;
   logic         in_ready_s;
   logic         transfer_s;
   logic         load_s;

   // Mix arithmetic, handshake and period-boundary decode.
   always_comb begin
      mix_s        = mix_f(ch_en, samples);
      cnt_max_s    = (cnt_r == CNT_MAX);
      period_end_s = cs & ~rst & cnt_max_s;
      in_ready_s   = cs & ~pend_full_r & ~rst;
      transfer_s   = in_valid & in_ready_s;
      load_s       = period_end_s & pend_full_r;
   end

   // PWM period counter; restarts from zero whenever the stage is cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {W{1'b0}};
      end else if (!cs) begin
         cnt_r <= {W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // Single-entry pending buffer: filled by a handshake transfer, emptied
   // when its value is promoted to the active duty at a period boundary.
   // A transfer and a load are mutually exclusive since in_ready is low
   // whenever the buffer is full.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r      <= {W{1'b0}};
         pend_full_r <= 1'b0;
      end else if (!cs) begin
         pend_r      <= pend_r;
         pend_full_r <= 1'b0;
      end else if (transfer_s) begin
         pend_r      <= mix_s;
         pend_full_r <= 1'b1;
      end else if (load_s) begin
         pend_r      <= pend_r;
         pend_full_r <= 1'b0;
      end else begin
         pend_r      <= pend_r;
         pend_full_r <= pend_full_r;
      end
   end

   // Active duty: only changes on the last cycle of a period with a value pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_r <= {W{1'b0}};
      end else if (!cs) begin
         duty_r <= {W{1'b0}};
      end else if (load_s) begin
         duty_r <= pend_r;
      end else begin
         duty_r <= duty_r;
      end
   end

   // Registered PWM compare; sigout lags the counter by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sigout_r <= 1'b0;
      end else if (!cs) begin
         sigout_r <= 1'b0;
      end else begin
         sigout_r <= (cnt_r < duty_r);
      end
   end

   assign in_ready   = in_ready_s;
   assign period_end = period_end_s;
   assign sigout     = sigout_r;
   assign mix_level  = duty_r;

endmodule

// File: tb/tb_pwm_voice_mixer.sv
// Scoreboard bench for pwm_voice_mixer: one averaging and one saturating
// instance share all inputs, so each transfer carries a pair of expected mixes.
module tb_pwm_voice_mixer;

   localparam int PER = 256;
   localparam int NV  = 9;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic [3:0]  ch_en;
   logic [31:0] samples;
   logic        in_valid;
   logic [1:0]  rdy;
   logic [1:0]  sig;
   logic [1:0]  pe;
   logic [1:0][7:0] ml;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   typedef struct {
      int cyc;
      int avg;
      int sat;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   mdl[2];
   int   hi[2];
   int   win_exp[2];
   bit   win_ok      = 1'b0;
   bit   pe_prev     = 1'b0;
   bit   prev_active = 1'b1;
   bit   done        = 1'b0;
   int   last_pe_cyc = -1000;
   int   run         = 0;

   logic [31:0] v_smp[NV];
   logic [3:0]  v_en[NV];
   int          v_avg[NV];
   int          v_sat[NV];

   pwm_voice_mixer #(.NUM_CH(4), .W(8), .SAT(0)) u_avg (
      .clk(clk), .rst(rst), .cs(cs), .ch_en(ch_en), .samples(samples),
      .in_valid(in_valid), .in_ready(rdy[0]), .sigout(sig[0]),
      .period_end(pe[0]), .mix_level(ml[0])
   );

   pwm_voice_mixer #(.NUM_CH(4), .W(8), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .cs(cs), .ch_en(ch_en), .samples(samples),
      .in_valid(in_valid), .in_ready(rdy[1]), .sigout(sig[1]),
      .period_end(pe[1]), .mix_level(ml[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: period timing, idle behaviour, duty updates and per-period high counts.
   always @(negedge clk) begin
      bit active;
      active = !rst && cs;
      if (active) run++;
      else run = 0;
      if (!done) begin
         for (int i = 0; i < 2; i++) begin
            check("period_end", int'(pe[i]), int'(run != 0 && (run % PER) == 0));
            if (!prev_active) check("sigout_idle", int'(sig[i]), 0);
            if (!active) check("in_ready_idle", int'(rdy[i]), 0);
         end
         if (pe_prev && active) begin
            for (int i = 0; i < 2; i++) begin
               hi[i] += int'(sig[i]);
               if (win_ok) check("high_count", hi[i], win_exp[i]);
            end
            if (sb.size() > 0 && sb[0].cyc < last_pe_cyc) begin
               e = sb.pop_front();
               mdl[0] = e.avg;
               mdl[1] = e.sat;
            end
            for (int i = 0; i < 2; i++) begin
               win_exp[i] = mdl[i];
               hi[i] = 0;
            end
            win_ok = 1'b1;
         end else begin
            for (int i = 0; i < 2; i++) hi[i] += int'(sig[i]);
         end
         if (active || !prev_active) begin
            for (int i = 0; i < 2; i++) check("mix_level", int'(ml[i]), mdl[i]);
         end
      end
      pe_prev = pe[0];
      if (pe[0]) last_pe_cyc = cyc;
      prev_active = active;
   end

   // Offer vector idx until accepted; junk is presented while not ready.
   task automatic send(input int idx, input bit first);
      int w;
      w = 0;
      in_valid = 1'b1;
      while (!rdy[0] && w < 700) begin
         samples = 32'($urandom);
         ch_en   = 4'($urandom_range(15, 0));
         @(posedge clk); #1;
         w++;
      end
      if (w >= 700) begin
         check("transfer_timeout", 0, 1);
      end else begin
         check("ready_agree", int'(rdy[1]), int'(rdy[0]));
         if (!first) check("transfer_slot", cyc - last_pe_cyc, 1);
         samples = v_smp[idx];
         ch_en   = v_en[idx];
         sb.push_back('{cyc, v_avg[idx], v_sat[idx]});
         @(posedge clk); #1;
         samples = 32'($urandom);
         ch_en   = 4'($urandom_range(15, 0));
      end
   endtask

   initial begin
      // Lanes packed {ch3, ch2, ch1, ch0}
      v_smp[0] = {8'd40, 8'd60, 8'd100, 8'd200};  v_en[0] = 4'b1111; v_avg[0] = 100; v_sat[0] = 255;
      v_smp[1] = {8'd255, 8'd255, 8'd255, 8'd255}; v_en[1] = 4'b0001; v_avg[1] = 63;  v_sat[1] = 255;
      v_smp[2] = {8'd0, 8'd60, 8'd100, 8'd200};   v_en[2] = 4'b1111; v_avg[2] = 90;  v_sat[2] = 255;
      v_smp[3] = {8'd0, 8'd0, 8'd0, 8'd0};        v_en[3] = 4'b1111; v_avg[3] = 0;   v_sat[3] = 0;
      v_smp[4] = {8'd255, 8'd255, 8'd255, 8'd255}; v_en[4] = 4'b1111; v_avg[4] = 255; v_sat[4] = 255;
      v_smp[5] = {8'd40, 8'd30, 8'd20, 8'd10};    v_en[5] = 4'b0101; v_avg[5] = 10;  v_sat[5] = 40;
      v_smp[6] = {8'd4, 8'd3, 8'd2, 8'd1};        v_en[6] = 4'b1010; v_avg[6] = 1;   v_sat[6] = 6;
      v_smp[7] = {8'd100, 8'd100, 8'd100, 8'd100}; v_en[7] = 4'b1110; v_avg[7] = 75;  v_sat[7] = 255;
      v_smp[8] = {8'd30, 8'd40, 8'd50, 8'd60};    v_en[8] = 4'b1111; v_avg[8] = 45;  v_sat[8] = 180;

      rst = 1'b1; cs = 1'b1; in_valid = 1'b0; ch_en = 4'b0000; samples = 32'd0;
      mdl = '{0, 0};
      win_ok = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         check("ready_after_reset", int'(rdy[i]), 1);
         check("level_after_reset", int'(ml[i]), 0);
         check("sigout_after_reset", int'(sig[i]), 0);
      end

      // Average 100 / full scale, then a second mix left pending
      send(0, 1'b1);
      send(1, 1'b0);
      repeat (60) @(posedge clk);
      #1;

      // Chip-select drop mid-period drops the pending mix and clears duty
      in_valid = 1'b0;
      cs = 1'b0;
      sb.delete();
      mdl = '{0, 0};
      win_ok = 1'b0;
      repeat (5) @(posedge clk);
      #1 cs = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         check("ready_after_cs", int'(rdy[i]), 1);
         check("level_after_cs", int'(ml[i]), 0);
      end

      // Backpressured stream, including duty 0 followed by full scale
      send(2, 1'b1);
      for (int k = 3; k < NV; k++) send(k, 1'b0);
      in_valid = 1'b0;
      repeat (600) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
